// File: rtl/counter_bcd_mod.sv
// N-digit BCD modulo counter with chainable carry/borrow, direction control,
// preset load and seven-segment outputs. Optional HOUR12_EN adds 12-hour display form.

module seven_segment (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   // seg = {g,f,e,d,c,b,a}, active high; non-BCD codes blank the digit
   always_comb begin
      seg = 7'h00;
      case (bcd)
         4'd0: seg = 7'h3F;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end
endmodule

module counter_bcd_mod #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  carry_in,
   input  logic                  dir,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
`ifdef HOUR12_EN
   input  logic                  mode12,
   output logic                  pm,
`endif
   output logic [4*DIGITS-1:0]   s,
   output logic [7*DIGITS-1:0]   q,
   output logic                  carry_out,
   output logic                  load_err
);
   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_up;
   logic [W-1:0] cnt_dn;
   logic         up_c;
   logic         dn_b;
   logic         digits_ok;
   logic [15:0]  ld_dec;
   logic         load_ok;
   logic         at_max;
   logic         at_zero;

   // Ripple BCD increment/decrement; terminal wrap is applied in the register
   always_comb begin
      cnt_up = cnt;
      cnt_dn = cnt;
      up_c   = 1'b1;
      dn_b   = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (up_c) begin
            if (cnt[4*k +: 4] == 4'd9) begin
               cnt_up[4*k +: 4] = 4'd0;
            end else begin
               cnt_up[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
               up_c = 1'b0;
            end
         end
         if (dn_b) begin
            if (cnt[4*k +: 4] == 4'd0) begin
               cnt_dn[4*k +: 4] = 4'd9;
            end else begin
               cnt_dn[4*k +: 4] = cnt[4*k +: 4] - 4'd1;
               dn_b = 1'b0;
            end
         end
      end
   end

   always_comb begin
      digits_ok = 1'b1;
      ld_dec    = 16'd0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (load_val[4*k +: 4] > 4'd9) digits_ok = 1'b0;
         ld_dec = 16'(ld_dec * 16'd10) + {12'd0, load_val[4*k +: 4]};
      end
      load_ok = digits_ok && (ld_dec < 16'(MODULUS));
   end

   assign at_max    = (cnt == MAX_BCD);
   assign at_zero   = (cnt == '0);
   assign carry_out = carry_in & ~load & ((dir & at_max) | (~dir & at_zero));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         load_err <= 1'b0;
      end else begin
         load_err <= load & ~load_ok;
         if (load) begin
            if (load_ok) cnt <= load_val;
         end else if (carry_in) begin
            if (dir) cnt <= at_max  ? '0      : cnt_up;
            else     cnt <= at_zero ? MAX_BCD : cnt_dn;
         end
      end
   end

`ifdef HOUR12_EN
   logic [15:0] cnt_dec;
   logic [15:0] hr12;
   logic [15:0] wide;

   always_comb begin
      cnt_dec = 16'd0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         cnt_dec = 16'(cnt_dec * 16'd10) + {12'd0, cnt[4*k +: 4]};
      end
   end

   // Only the display is remapped; counting and load stay in 24-hour terms
   always_comb begin
      wide = 16'd0;
      wide[W-1:0] = cnt;
      hr12 = cnt_dec - 16'd12;
      if (MODULUS == 24 && mode12) begin
         if (cnt_dec == 16'd0)
            wide[7:0] = 8'h12;
         else if (cnt_dec >= 16'd13)
            wide[7:0] = (hr12 >= 16'd10) ? {4'd1, 4'(hr12 - 16'd10)} : {4'd0, hr12[3:0]};
      end
      s = wide[W-1:0];
   end

   assign pm = (cnt_dec >= 16'd12);
`else
   assign s = cnt;
`endif

   for (genvar k = 0; k < DIGITS; k++) begin : g_seg
      seven_segment u_seg (
         .bcd (s[4*k +: 4]),
         .seg (q[7*k +: 7])
      );
   end
endmodule

// File: tb/tb_counter_bcd_mod.sv
// Directed bench for counter_bcd_mod: vector table on a mod-24 counter plus
// hand sequences for full count, mod-60 borrow, chaining, async reset and HOUR12_EN.

module tb_counter_bcd_mod;
   logic clk;
   logic reset;

   logic        ci, dir, ld;
   logic [7:0]  lv;
   logic [7:0]  s24;
   logic [13:0] q24;
   logic        co24, err24;
   logic        mode12, pm24;

   logic        ci60, dir60, ld60;
   logic [7:0]  lv60, s60;
   logic [13:0] q60;
   logic        co60, err60, pm60;

   logic        sec_ci, ch_dir, ch_ld;
   logic [7:0]  sec_lv, hr_lv, s_sec, s_hr;
   logic [13:0] q_sec, q_hr;
   logic        co_sec, co_hr, err_sec, err_hr, pm_sec, pm_hr;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   counter_bcd_mod #(.DIGITS(2), .MODULUS(24)) dut (
      .clk(clk), .reset(reset), .carry_in(ci), .dir(dir), .load(ld), .load_val(lv),
`ifdef HOUR12_EN
      .mode12(mode12), .pm(pm24),
`endif
      .s(s24), .q(q24), .carry_out(co24), .load_err(err24));

   counter_bcd_mod #(.DIGITS(2), .MODULUS(60)) d60 (
      .clk(clk), .reset(reset), .carry_in(ci60), .dir(dir60), .load(ld60), .load_val(lv60),
`ifdef HOUR12_EN
      .mode12(1'b0), .pm(pm60),
`endif
      .s(s60), .q(q60), .carry_out(co60), .load_err(err60));

   counter_bcd_mod #(.DIGITS(2), .MODULUS(60)) ch_sec (
      .clk(clk), .reset(reset), .carry_in(sec_ci), .dir(ch_dir), .load(ch_ld), .load_val(sec_lv),
`ifdef HOUR12_EN
      .mode12(1'b0), .pm(pm_sec),
`endif
      .s(s_sec), .q(q_sec), .carry_out(co_sec), .load_err(err_sec));

   counter_bcd_mod #(.DIGITS(2), .MODULUS(24)) ch_hr (
      .clk(clk), .reset(reset), .carry_in(co_sec), .dir(ch_dir), .load(ch_ld), .load_val(hr_lv),
`ifdef HOUR12_EN
      .mode12(1'b0), .pm(pm_hr),
`endif
      .s(s_hr), .q(q_hr), .carry_out(co_hr), .load_err(err_hr));

   typedef struct {
      logic       ld;
      logic [7:0] lv;
      logic       ci;
      logic       dir;
      logic [7:0] s;
      logic       co;
      logic       err;
   } vec_t;

   vec_t vecs[18];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [13:0] seg2(input logic [7:0] v);
      return {seg7(v[7:4]), seg7(v[3:0])};
   endfunction

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive at negedge, check carry_out before the edge, s/load_err/q after it
   task automatic step24(input logic l, input logic [7:0] v, input logic c, input logic d,
                         input logic [7:0] es, input logic eco, input logic eerr, input string tag);
      @(negedge clk);
      ld = l; lv = v; ci = c; dir = d;
      #1 check({tag, " carry_out"}, 32'(co24), 32'(eco));
      @(posedge clk);
      #1;
      check({tag, " s"}, 32'(s24), 32'(es));
      check({tag, " load_err"}, 32'(err24), 32'(eerr));
      check({tag, " q"}, 32'(q24), 32'(seg2(es)));
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h25, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h1A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 8'h18, 1'b1, 1'b1, 8'h18, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h19, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h23, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h23, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 8'h23, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 8'h24, 1'b0, 1'b1, 8'h23, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 8'h09, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0};

      reset = 1'b0;
      ci = 0; dir = 1; ld = 0; lv = 8'h00; mode12 = 1'b0;
      ci60 = 0; dir60 = 1; ld60 = 0; lv60 = 8'h00;
      sec_ci = 0; ch_dir = 1; ch_ld = 0; sec_lv = 8'h00; hr_lv = 8'h00;

      #12;
      check("reset s", 32'(s24), 32'h00);
      check("reset load_err", 32'(err24), 32'h0);
      check("reset q", 32'(q24), 32'(seg2(8'h00)));
      check("reset carry_out", 32'(co24), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step24(vecs[i].ld, vecs[i].lv, vecs[i].ci, vecs[i].dir,
                vecs[i].s, vecs[i].co, vecs[i].err, $sformatf("vec%0d", i));
      end

      // Full mod-24 up count from 0 with carry_out only at 23
      step24(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "ld0");
      for (int i = 0; i < 24; i++) begin
         step24(1'b0, 8'h00, 1'b1, 1'b1, bcd2((i + 1) % 24), (i == 23), 1'b0,
                $sformatf("up%0d", i));
      end
      @(negedge clk);
      ci = 0; ld = 0;

      // Mod-60 down count: 00 borrows to 59, then 50 -> 49
      ci60 = 1; dir60 = 0;
      #1 check("m60 borrow carry_out", 32'(co60), 32'h1);
      @(posedge clk); #1 check("m60 wrap s", 32'(s60), 32'h59);
      @(negedge clk);
      ci60 = 0; ld60 = 1; lv60 = 8'h50;
      @(posedge clk); #1 check("m60 load s", 32'(s60), 32'h50);
      @(negedge clk);
      ld60 = 0; ci60 = 1;
      #1 check("m60 50 carry_out", 32'(co60), 32'h0);
      @(posedge clk); #1 check("m60 dec s", 32'(s60), 32'h49);
      check("m60 q", 32'(q60), 32'(seg2(8'h49)));
      @(negedge clk);
      ci60 = 0;

      // Chained 23:59 -> 00:00 on one edge
      ch_ld = 1; sec_lv = 8'h59; hr_lv = 8'h23;
      @(posedge clk); #1;
      check("chain load sec", 32'(s_sec), 32'h59);
      check("chain load hr", 32'(s_hr), 32'h23);
      @(negedge clk);
      ch_ld = 0; sec_ci = 1;
      #1;
      check("chain sec carry", 32'(co_sec), 32'h1);
      check("chain hr carry", 32'(co_hr), 32'h1);
      @(posedge clk); #1;
      check("chain wrap sec", 32'(s_sec), 32'h00);
      check("chain wrap hr", 32'(s_hr), 32'h00);
      @(negedge clk);
      #1 check("chain sec carry idle", 32'(co_sec), 32'h0);
      @(posedge clk); #1;
      check("chain step sec", 32'(s_sec), 32'h01);
      check("chain hold hr", 32'(s_hr), 32'h00);
      @(negedge clk);
      sec_ci = 0;

      // Asynchronous reset mid-count with a pending load_err
      ld = 1; lv = 8'h17;
      @(posedge clk);
      @(negedge clk);
      lv = 8'h99;
      @(posedge clk); #1;
      check("pre-reset s", 32'(s24), 32'h17);
      check("pre-reset load_err", 32'(err24), 32'h1);
      reset = 1'b0; ld = 0;
      #1;
      check("async reset s", 32'(s24), 32'h00);
      check("async reset load_err", 32'(err24), 32'h0);
      check("async reset q", 32'(q24), 32'(seg2(8'h00)));
      #5;
      @(negedge clk);
      reset = 1'b1;
      step24(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "post-reset");
      @(negedge clk);
      ci = 0;

`ifdef HOUR12_EN
      ld = 1; lv = 8'h00;
      @(posedge clk);
      @(negedge clk);
      ld = 0; mode12 = 1;
      #1;
      check("h12 0 s", 32'(s24), 32'h12);
      check("h12 0 pm", 32'(pm24), 32'h0);
      check("h12 0 q", 32'(q24), 32'(seg2(8'h12)));
      ld = 1; lv = 8'h13;
      @(posedge clk); #1;
      check("h12 13 s", 32'(s24), 32'h01);
      check("h12 13 pm", 32'(pm24), 32'h1);
      @(negedge clk);
      lv = 8'h12;
      @(posedge clk); #1;
      check("h12 12 s", 32'(s24), 32'h12);
      check("h12 12 pm", 32'(pm24), 32'h1);
      @(negedge clk);
      lv = 8'h23;
      @(posedge clk); #1;
      check("h12 23 s", 32'(s24), 32'h11);
      @(negedge clk);
      ld = 0; ci = 1; dir = 1;
      #1 check("h12 23 carry_out", 32'(co24), 32'h1);
      @(posedge clk); #1;
      check("h12 wrap s", 32'(s24), 32'h12);
      check("h12 wrap pm", 32'(pm24), 32'h0);
      @(negedge clk);
      ci = 0; mode12 = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/counter_bcd_mod.md
Name: counter_bcd_mod

Overview:
- Parametrised N-digit BCD modulo counter with chainable carry, direction control, synchronous preset load and per-digit seven-segment outputs.
- Generalises the fixed two-digit hour counter so one block serves seconds (mod 60), minutes (mod 60), hours (mod 24) and day or other counters in the clock datapath.
- Sits between a lower-order counter's carry_out and the display drivers.

Parameters:
- DIGITS, 2, number of BCD digits (legal 1..4).
- MODULUS, 24, count range 0..MODULUS-1 (legal 2..10^DIGITS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- carry_in  in  1  count enable (one step per cycle while high).
- dir  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous preset strobe.
- load_val  in  4*DIGITS  BCD preset value, digit 0 in [3:0].
- s  out  4*DIGITS  current BCD value, digit 0 in [3:0].
- q  out  7*DIGITS  seven-segment codes, digit k at [7k+6:7k], via existing seven_segment.
- carry_out  out  1  combinational terminal-count carry/borrow for chaining.
- load_err  out  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (reset = 0, asynchronous): s = 0, load_err = 0, q = seven-seg code of 0 on every digit; carry_out follows its equation.
- Priority per rising clk edge: load > carry_in > hold.
- Load validity: every digit of load_val must be ≤ 9 and the decimal value must be < MODULUS.
  - Valid load: s = load_val next cycle, load_err = 0.
  - Invalid load: s holds, load_err = 1 for exactly one cycle.
  - carry_in is ignored in any cycle with load = 1.
- Up count (carry_in = 1, dir = 1): s + 1 in BCD. A digit at 9 rolls to 0 and increments the next digit. At MODULUS-1 the value wraps to 0.
- Down count (carry_in = 1, dir = 0): s - 1 in BCD. A digit at 0 becomes 9 and borrows from the next digit. At 0 the value wraps to MODULUS-1.
- carry_out = carry_in & ~load & ((dir & s == MODULUS-1) | (~dir & s == 0)). Combinational, same cycle, so the next stage steps on the same edge.
- Latency: load or step is visible on s one cycle after the edge. q is combinational from s.
- Digits above the MODULUS range (e.g. digit 1 for MODULUS ≤ 10) stay 0.
- Reset mid-count: the value is lost immediately; counting resumes from 0 after reset releases.
- load_err is cleared on any cycle without an invalid load.

Optional Feature:
- Macro: HOUR12_EN.
- Defined:
  - Adds input mode12 (1 bit) and output pm (1 bit).
  - Internal count is unchanged (0..MODULUS-1).
  - When mode12 = 1 and MODULUS = 24, s and q show 12-hour form: 0 → 12, 1..12 unchanged, 13..23 → 1..11.
  - pm = 1 when the internal value ≥ 12 (regardless of mode12); reset value 0.
  - carry_out and load are unaffected. load_val is always interpreted as a 24-hour value.
- Undefined: the ports are absent, and s always equals the internal count.

Test Plan:
- Reset low mid-count at s = 0x17 → s = 0x00 and load_err = 0 immediately, without waiting for a clk edge.
- MODULUS = 24, dir = 1, carry_in held high from 0 → sequence 0x00..0x09, 0x10..0x19, 0x20..0x23, 0x00. carry_out is high only while s = 0x23.
- MODULUS = 60, dir = 0, from 0x00 → next 0x59 with carry_out = 1 during the 0x00 cycle; then 0x50 → 0x49.
- Load 0x25 with MODULUS = 24 → s holds, load_err = 1 for one cycle. Load 0x1A → rejected. Load 0x18 together with carry_in = 1 → s = 0x18, carry_out = 0.
- Two instances chained, mod 60 carry_out → mod 24 carry_in, starting at 23:59 → both wrap to 00:00 on the same edge.
- HOUR12_EN with mode12 = 1: internal 0 → s = 0x12, pm = 0; internal 13 → s = 0x01, pm = 1; internal 12 → s = 0x12, pm = 1.
